// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, clog2 helper and elaboration-time parameter checks
// for the fifo_param buffer family.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Depth must be a power of two in 2..1024; expands to a generate item.
`define FIFO_CHECK_DEPTH(depth) \
    if (((depth) < 2) || ((depth) > 1024) || ((((depth) & ((depth) - 1))) != 0)) begin : g_bad_depth \
        $error("fifo_param: DEPTH must be a power of two in 2..1024"); \
    end

// Afull threshold in 1..DEPTH, Aempty threshold in 0..DEPTH-1; expands to a generate item.
`define FIFO_CHECK_TH(depth, afull, aempty) \
    if (((afull) < 1) || ((afull) > (depth)) || ((aempty) > ((depth) - 1))) begin : g_bad_th \
        $error("fifo_param: AFULL_TH/AEMPTY_TH out of range"); \
    end

package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register file, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AW    = clog2(FIFO_DEPTH_DEF)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the write word on an accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock show-ahead FIFO with occupancy count,
// almost-full/almost-empty thresholds and active-low write/read enables.
// Optional sticky Ovf/Udf error flags with ErrClr are built when FIFO_ERR_EN is defined.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 4,
    localparam int unsigned AW       = clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             rst,
`ifdef FIFO_ERR_EN
    input  logic             ErrClr,
    output logic             Ovf,
    output logic             Udf,
`endif
    input  logic [WIDTH-1:0] Din,
    input  logic             Wen,
    input  logic             Ren,
    output logic [WIDTH-1:0] Dout,
    output logic             Fempty,
    output logic             Ffull,
    output logic             Aempty,
    output logic             Afull,
    output logic [AW:0]      Count
);

    `FIFO_CHECK_DEPTH(DEPTH)
    `FIFO_CHECK_TH(DEPTH, AFULL_TH, AEMPTY_TH)

    localparam logic [AW:0] PTR_INC    = (AW + 1)'(1);
    localparam logic [AW:0] AFULL_LVL  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LVL = (AW + 1)'(AEMPTY_TH);

    // Pointers carry an extra wrap bit above the AW address bits.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic        empty, full, we, rd;

    // Flags and accept strobes, all from registered state.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        rd    = !Ren && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
        we    = !Wen && (!full || rd);
    end

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (we) begin
            wptr_d = wptr_q + PTR_INC;
        end
        if (rd) begin
            rptr_d = rptr_q + PTR_INC;
        end
        case ({we, rd})
            2'b10:   count_d = count_q + PTR_INC;
            2'b01:   count_d = count_q - PTR_INC;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (ck),
        .we_i    (we),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (Din),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (Dout)
    );

    assign Fempty = empty;
    assign Ffull  = full;
    assign Aempty = (count_q <= AEMPTY_LVL);
    assign Afull  = (count_q >= AFULL_LVL);
    assign Count  = count_q;

`ifdef FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags; a new error in the ErrClr cycle wins over the clear.
    always_comb begin
        ovf_d = (ovf_q && !ErrClr) || (!Wen && full && !rd);
        udf_d = (udf_q && !ErrClr) || (!Ren && empty);
    end

    // Error flag registers.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign Ovf = ovf_q;
    assign Udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for fifo_param (WIDTH=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4).
// Define FIFO_ERR_EN to also exercise the sticky Ovf/Udf flags.
module tb_fifo_param;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AFULL_TH  = 12;
    localparam int unsigned AEMPTY_TH = 4;

    logic             ck;
    logic             rst;
    logic [WIDTH-1:0] Din;
    logic             Wen;
    logic             Ren;
    logic [WIDTH-1:0] Dout;
    logic             Fempty;
    logic             Ffull;
    logic             Aempty;
    logic             Afull;
    logic [4:0]       Count;
    logic             ErrClr;
    logic             Ovf;
    logic             Udf;

    fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .ck     (ck),
        .rst    (rst),
`ifdef FIFO_ERR_EN
        .ErrClr (ErrClr),
        .Ovf    (Ovf),
        .Udf    (Udf),
`endif
        .Din    (Din),
        .Wen    (Wen),
        .Ren    (Ren),
        .Dout   (Dout),
        .Fempty (Fempty),
        .Ffull  (Ffull),
        .Aempty (Aempty),
        .Afull  (Afull),
        .Count  (Count)
    );

`ifndef FIFO_ERR_EN
    assign Ovf = 1'b0;
    assign Udf = 1'b0;
`endif

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Expected observable state for one cycle, as seen between edges.
    typedef struct {
        int               cnt;
        logic             has_head;
        logic [WIDTH-1:0] head;
        logic             ovf;
        logic             udf;
    } exp_t;

    exp_t             state_q[$];   // per-cycle expectations
    logic [WIDTH-1:0] rd_q[$];      // data expected on each DUT pop
    logic [WIDTH-1:0] model_q[$];   // reference FIFO contents
    logic             ovf_m;
    logic             udf_m;

    int checks;
    int failures;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Issue one cycle of stimulus and record what the reference model expects.
    task automatic drive(input logic wen, input logic ren, input logic [WIDTH-1:0] din,
                         input logic clr);
        exp_t e;
        int   occ;
        logic rd_ok;
        logic wr_ok;
        @(posedge ck);
        #1;
        Wen    = wen;
        Ren    = ren;
        Din    = din;
        ErrClr = clr;
        occ        = model_q.size();
        e.cnt      = occ;
        e.has_head = (occ > 0);
        e.head     = '0;
        if (occ > 0) e.head = model_q[0];
        e.ovf      = ovf_m;
        e.udf      = udf_m;
        state_q.push_back(e);
        rd_ok = !ren && (occ > 0);
        wr_ok = !wen && ((occ < int'(DEPTH)) || rd_ok);
        if (rd_ok) rd_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(din);
        ovf_m = (ovf_m && !clr) || (!wen && !wr_ok);
        udf_m = (udf_m && !clr) || (!ren && (occ == 0));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 64'(Count), 64'd0);
        chk({tag, "_fempty"}, 64'(Fempty), 64'd1);
        chk({tag, "_ffull"}, 64'(Ffull), 64'd0);
        chk({tag, "_aempty"}, 64'(Aempty), 64'd1);
        chk({tag, "_afull"}, 64'(Afull), 64'd0);
`ifdef FIFO_ERR_EN
        chk({tag, "_ovf"}, 64'(Ovf), 64'd0);
        chk({tag, "_udf"}, 64'(Udf), 64'd0);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge ck);
        #1;
        Wen    = 1'b1;
        Ren    = 1'b1;
        ErrClr = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_reset_state("midrst");
        rst = 1'b1;
        model_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // Monitor: compare each recorded cycle and every DUT pop.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                chk("count", 64'(Count), 64'(e.cnt));
                chk("fempty", 64'(Fempty), 64'(e.cnt == 0));
                chk("ffull", 64'(Ffull), 64'(e.cnt == int'(DEPTH)));
                chk("aempty", 64'(Aempty), 64'(e.cnt <= int'(AEMPTY_TH)));
                chk("afull", 64'(Afull), 64'(e.cnt >= int'(AFULL_TH)));
                if (e.has_head) chk("dout_head", 64'(Dout), 64'(e.head));
`ifdef FIFO_ERR_EN
                chk("ovf", 64'(Ovf), 64'(e.ovf));
                chk("udf", 64'(Udf), 64'(e.udf));
`endif
            end
            if (!Ren && !Fempty) begin
                chk("read_pending", 64'(rd_q.size() > 0), 64'd1);
                if (rd_q.size() > 0) chk("read_data", 64'(Dout), 64'(rd_q.pop_front()));
            end
        end
    end

    // Stimulus.
    initial begin
        int wprob;
        int rprob;
        checks   = 0;
        failures = 0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
        rst      = 1'b0;
        Wen      = 1'b1;
        Ren      = 1'b1;
        Din      = '0;
        ErrClr   = 1'b0;
        #3;
        check_reset_state("reset");
        #9 rst = 1'b1;

        drive(1'b1, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Write while full with no read: dropped.
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Simultaneous read and write while full, across pointer wrap.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Drain everything.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Read while empty, then write+read on empty.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h5C, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
        reset_pulse();
        drive(1'b1, 1'b1, 8'h00, 1'b0);

        // Randomised traffic with shifting write/read bias.
        for (int p = 0; p < 20; p++) begin
            wprob = 20 + 30 * int'($urandom_range(2));
            rprob = 20 + 30 * int'($urandom_range(2));
            for (int i = 0; i < 500; i++) begin
                drive(($urandom_range(99) < 32'(wprob)) ? 1'b0 : 1'b1,
                      ($urandom_range(99) < 32'(rprob)) ? 1'b0 : 1'b1,
                      8'($urandom_range(255)),
                      ($urandom_range(99) < 5) ? 1'b1 : 1'b0);
            end
        end

        drive(1'b1, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        @(negedge ck);
        #1;
        chk("reads_outstanding", 64'(rd_q.size()), 64'd0);
        chk("cycles_unchecked", 64'(state_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
